// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO: producer handshake, RAM write
// port, pointer exchange with the read domain and the write-side status flags.
interface fifo_wr_ctrl_if #(
   parameter int unsigned ADDR_W = 3
);

   logic              winc;
   logic              wovf_clr;
   logic [ADDR_W:0]   rptr_gray;
   logic              wen;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   wptr_gray;
   logic              wfull;
   logic              walmost_full;
   logic [ADDR_W:0]   wlevel;
   logic              woverflow;

   // Producer / environment side
   modport master (
      output winc,
      output wovf_clr,
      output rptr_gray,
      input  wen,
      input  waddr,
      input  wptr_gray,
      input  wfull,
      input  walmost_full,
      input  wlevel,
      input  woverflow
   );

   // Write controller side
   modport slave (
      input  winc,
      input  wovf_clr,
      input  rptr_gray,
      output wen,
      output waddr,
      output wptr_gray,
      output wfull,
      output walmost_full,
      output wlevel,
      output woverflow
   );

endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO. Keeps the binary and Gray
// write pointers, drives the RAM write port, synchronises the read pointer
// into wclk and derives full / almost-full / level / sticky overflow.
module fifo_wr_ctrl #(
   parameter int unsigned ADDR_W      = 3,
   parameter int unsigned AFULL_TH    = 6,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         wclk,
   input  logic         wrst,
   fifo_wr_ctrl_if.slave bus
);

   localparam int unsigned PW = ADDR_W + 1;
   localparam logic [ADDR_W:0] AFULL_LVL = PW'(AFULL_TH);

   // Elaboration-time parameter sanity
   if (ADDR_W < 2) begin : g_bad_addr_w
      $error("fifo_wr_ctrl: ADDR_W must be at least 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("fifo_wr_ctrl: SYNC_STAGES must be at least 2");
   end
   if ((AFULL_TH < 1) || (AFULL_TH > (1 << ADDR_W))) begin : g_bad_afull
      $error("fifo_wr_ctrl: AFULL_TH out of range 1..2**ADDR_W");
   end

   logic [ADDR_W:0] wbin_q;
   logic [ADDR_W:0] wptr_gray_q;
   logic            wfull_q;
   logic            walmost_full_q;
   logic [ADDR_W:0] wlevel_q;
   logic            woverflow_q;
   logic [ADDR_W:0] rq_q [SYNC_STAGES];

   logic            wen_int;
   logic [ADDR_W:0] wbin_next;
   logic [ADDR_W:0] wgray_next;
   logic [ADDR_W:0] rq_sync;
   logic [ADDR_W:0] rbin;
   logic [ADDR_W:0] full_ref;
   logic [ADDR_W:0] level_next;

   // Writes are dropped while full; reset forces the RAM port idle at once
   assign wen_int    = bus.winc & ~wfull_q & ~wrst;
   assign wbin_next  = wbin_q + {{ADDR_W{1'b0}}, wen_int};
   assign wgray_next = wbin_next ^ (wbin_next >> 1);
   assign rq_sync    = rq_q[SYNC_STAGES-1];

   // Full when the next write pointer is a whole lap ahead of the read pointer:
   // in Gray form that is the read pointer with its two MSBs inverted.
   assign full_ref   = {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]};
   assign level_next = wbin_next - rbin;

   // Gray-to-binary of the synchronised read pointer (XOR prefix from MSB)
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= int'(ADDR_W); i++) begin
         rbin[i] = ^(rq_sync >> i);
      end
   end

   // Read-pointer synchroniser: plain flop chain, no logic between stages
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) begin
            rq_q[s] <= '0;
         end
      end else begin
         rq_q[0] <= bus.rptr_gray;
         for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            rq_q[s] <= rq_q[s-1];
         end
      end
   end

   // Write pointer in binary and registered Gray form
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin_q      <= '0;
         wptr_gray_q <= '0;
      end else begin
         wbin_q      <= wbin_next;
         wptr_gray_q <= wgray_next;
      end
   end

   // Status flags, all computed from the post-write pointer so full asserts
   // on the edge that stores the last word
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wfull_q        <= 1'b0;
         walmost_full_q <= 1'b0;
         wlevel_q       <= '0;
      end else begin
         wfull_q        <= (wgray_next == full_ref);
         walmost_full_q <= (level_next >= AFULL_LVL);
         wlevel_q       <= level_next;
      end
   end

   // Sticky overflow; a new overflow beats a simultaneous clear
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         woverflow_q <= 1'b0;
      end else if (bus.winc & wfull_q) begin
         woverflow_q <= 1'b1;
      end else if (bus.wovf_clr) begin
         woverflow_q <= 1'b0;
      end
   end

   assign bus.wen          = wen_int;
   assign bus.waddr        = wbin_q[ADDR_W-1:0];
   assign bus.wptr_gray    = wptr_gray_q;
   assign bus.wfull        = wfull_q;
   assign bus.walmost_full = walmost_full_q;
   assign bus.wlevel       = wlevel_q;
   assign bus.woverflow    = woverflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl (ADDR_W=3, AFULL_TH=6, SYNC_STAGES=2).
// A behavioural occupancy model predicts post-edge state into a scoreboard
// queue at drive time; entries are popped and checked after the edge.
module tb_fifo_wr_ctrl;

   localparam int unsigned AW = 3;

   typedef struct {
      logic [AW:0] gray;
      logic [AW:0] lvl;
      logic        full;
      logic        afull;
      logic        ovf;
   } exp_t;

   logic wclk;
   logic wrst;
   int   n_tests;
   int   n_fail;

   exp_t sb[$];

   // Model state: writes committed, two-stage view of the read pointer
   logic [AW:0] m_wbin;
   logic [AW:0] m_s1;
   logic [AW:0] m_s2;
   logic        m_full;
   logic        m_ovf;

   fifo_wr_ctrl_if #(.ADDR_W(AW)) bus ();

   fifo_wr_ctrl #(
      .ADDR_W      (AW),
      .AFULL_TH    (6),
      .SYNC_STAGES (2)
   ) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [AW:0] to_gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wbin = '0;
      m_s1   = '0;
      m_s2   = '0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
      sb.delete();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_wen"},   32'(bus.wen),          32'd0);
      chk({tag, "_waddr"}, 32'(bus.waddr),        32'd0);
      chk({tag, "_gray"},  32'(bus.wptr_gray),    32'd0);
      chk({tag, "_full"},  32'(bus.wfull),        32'd0);
      chk({tag, "_afull"}, 32'(bus.walmost_full), 32'd0);
      chk({tag, "_lvl"},   32'(bus.wlevel),       32'd0);
      chk({tag, "_ovf"},   32'(bus.woverflow),    32'd0);
   endtask

   // Called at posedge+1; returns at the following posedge+1
   task automatic do_reset();
      wrst          = 1'b1;
      bus.winc      = 1'b0;
      bus.wovf_clr  = 1'b0;
      bus.rptr_gray = '0;
      repeat (2) @(posedge wclk);
      #1;
      wrst = 1'b0;
      model_reset();
   endtask

   // One write-clock cycle: drive, check combinational outputs, predict, clock, check
   task automatic step(input logic inc, input logic clr, input logic [AW:0] rb);
      logic        exp_wen;
      logic [AW:0] nb;
      logic [AW:0] lvl;
      exp_t        e;
      exp_t        got;
      bus.winc      = inc;
      bus.wovf_clr  = clr;
      bus.rptr_gray = to_gray(rb);
      #1;
      exp_wen = inc & ~m_full;
      chk("wen",   32'(bus.wen),   32'(exp_wen));
      chk("waddr", 32'(bus.waddr), 32'(m_wbin[AW-1:0]));
      nb      = m_wbin + {{AW{1'b0}}, exp_wen};
      lvl     = nb - m_s2;
      e.gray  = to_gray(nb);
      e.lvl   = lvl;
      e.full  = (lvl == 4'd8);
      e.afull = (lvl >= 4'd6);
      e.ovf   = (inc & m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      sb.push_back(e);
      m_wbin = nb;
      m_full = e.full;
      m_ovf  = e.ovf;
      m_s2   = m_s1;
      m_s1   = rb;
      @(posedge wclk);
      #1;
      got = sb.pop_front();
      chk("wptr_gray",    32'(bus.wptr_gray),    32'(got.gray));
      chk("wlevel",       32'(bus.wlevel),       32'(got.lvl));
      chk("wfull",        32'(bus.wfull),        32'(got.full));
      chk("walmost_full", 32'(bus.walmost_full), 32'(got.afull));
      chk("woverflow",    32'(bus.woverflow),    32'(got.ovf));
   endtask

   initial begin
      logic [AW:0]   prev_g;
      logic [AW-1:0] prev_a;
      logic [AW:0]   hist[$];
      int            wraps;
      n_tests = 0;
      n_fail  = 0;
      model_reset();
      wrst          = 1'b1;
      bus.winc      = 1'b0;
      bus.wovf_clr  = 1'b0;
      bus.rptr_gray = '0;
      @(posedge wclk);
      #1;
      chk_idle("por");
      do_reset();
      chk_idle("rst_rel");

      // 1: asynchronous reset in mid-cycle while writing
      repeat (3) step(1'b1, 1'b0, '0);
      bus.winc = 1'b1;
      #3;
      wrst = 1'b1;
      #1;
      chk_idle("async_rst");
      @(posedge wclk);
      #1;
      chk_idle("async_rst_hold");
      wrst = 1'b0;
      model_reset();
      step(1'b1, 1'b0, '0);

      // 2: fill from empty
      do_reset();
      for (int i = 0; i < 8; i++) begin
         chk("fill_addr", 32'(bus.waddr), i);
         step(1'b1, 1'b0, '0);
         if (i == 4) chk("afull_pre", 32'(bus.walmost_full), 32'd0);
         if (i == 5) begin
            chk("afull_at6", 32'(bus.walmost_full), 32'd1);
            chk("lvl_at6",   32'(bus.wlevel),       32'd6);
         end
      end
      chk("full_gray", 32'(bus.wptr_gray), 32'hC);
      chk("full_flag", 32'(bus.wfull),     32'd1);
      chk("full_lvl",  32'(bus.wlevel),    32'd8);

      // 3: overflow behaviour
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      chk("ovf_gray", 32'(bus.wptr_gray), 32'hC);
      chk("ovf_set",  32'(bus.woverflow), 32'd1);
      step(1'b0, 1'b1, '0);
      chk("ovf_clr", 32'(bus.woverflow), 32'd0);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, '0);
      chk("ovf_set_wins", 32'(bus.woverflow), 32'd1);

      // 4: one read seen through the synchroniser
      step(1'b0, 1'b0, 4'd1);
      chk("lat_e1_full", 32'(bus.wfull), 32'd1);
      step(1'b0, 1'b0, 4'd1);
      chk("lat_e2_full", 32'(bus.wfull), 32'd1);
      step(1'b0, 1'b0, 4'd1);
      chk("lat_e3_full",  32'(bus.wfull),        32'd0);
      chk("lat_e3_lvl",   32'(bus.wlevel),       32'd7);
      chk("lat_e3_afull", 32'(bus.walmost_full), 32'd1);

      // 5: pointer wrap with the reader trailing two cycles behind
      do_reset();
      wraps = 0;
      for (int i = 0; i < 20; i++) begin
         hist.push_back(m_wbin);
         prev_g = bus.wptr_gray;
         prev_a = bus.waddr;
         step(1'b1, 1'b0, (i >= 2) ? hist[i-2] : 4'd0);
         chk("gray_hd1", $countones(prev_g ^ bus.wptr_gray), 32'd1);
         if (prev_a == 3'd7 && bus.waddr == 3'd0) wraps++;
         if (i == 15) begin
            chk("wrap_prev_gray", 32'(prev_g),        32'h8);
            chk("wrap_gray",      32'(bus.wptr_gray), 32'h0);
         end
      end
      chk("addr_wraps", wraps, 32'd2);

      // 6: one-cycle reset pulse from full, then refill
      do_reset();
      repeat (8) step(1'b1, 1'b0, '0);
      chk("pre_pulse_full", 32'(bus.wfull), 32'd1);
      wrst = 1'b1;
      @(posedge wclk);
      #1;
      wrst = 1'b0;
      model_reset();
      chk("pulse_full", 32'(bus.wfull),     32'd0);
      chk("pulse_lvl",  32'(bus.wlevel),    32'd0);
      chk("pulse_gray", 32'(bus.wptr_gray), 32'd0);
      repeat (8) step(1'b1, 1'b0, '0);
      chk("refill_full", 32'(bus.wfull),  32'd1);
      chk("refill_lvl",  32'(bus.wlevel), 32'd8);
      chk("sb_empty",    sb.size(),       32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
